// File: rtl/ark_pkg.sv
// Shared encodings and playfield geometry for the ball engine.
package ark_pkg;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_LOST  = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;
  localparam logic [2:0] ST_CLEAR = 3'd6;

  localparam logic DIR_DEC = 1'b0;
  localparam logic DIR_INC = 1'b1;

  typedef enum logic [1:0] {
    HIT_UP    = 2'b00,
    HIT_RIGHT = 2'b01,
    HIT_DOWN  = 2'b10,
    HIT_LEFT  = 2'b11
  } hit_side_t;

  localparam logic [9:0] LEFT   = 10'd160;
  localparam logic [9:0] TOP    = 10'd0;
  localparam logic [9:0] MAXX   = 10'd320;
  localparam logic [9:0] MAXY   = 10'd480;
  localparam logic [9:0] HOME_X = 10'd320;
  localparam logic [9:0] HOME_Y = 10'd240;

endpackage

// File: rtl/axis_stepper.sv
// One axis of one ball: fractional step accumulator, coordinate and direction.
module axis_stepper
  import ark_pkg::*;
#(
  parameter int         UNIT    = 16,
  parameter logic [9:0] RST_POS = 10'd320,
  parameter logic       RST_DIR = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_en,
  input  logic [2:0] i_speed,
  input  logic       i_load,
  input  logic [9:0] i_load_pos,
  input  logic       i_load_dir,
  input  logic       i_force_inc,
  input  logic       i_force_dec,
  input  logic       i_hit,
  input  logic       i_hit_dir,
  output logic [9:0] o_pos,
  output logic       o_dir
);

  // Wide enough for UNIT+7, so the remainder after a step is never lost.
  localparam int AW = $clog2(UNIT + 8);

  logic [AW-1:0] r_acc;
  logic [9:0]    r_pos;
  logic          r_dir;
  logic [AW-1:0] w_sum;
  logic          w_step;
  logic          w_dir_next;

  // Walls beat hits; the step taken this cycle already uses the new direction.
  always_comb begin
    w_sum  = r_acc + {{(AW-3){1'b0}}, i_speed};
    w_step = (w_sum >= AW'(UNIT));
    if (i_force_inc) begin
      w_dir_next = DIR_INC;
    end else if (i_force_dec) begin
      w_dir_next = DIR_DEC;
    end else if (i_hit) begin
      w_dir_next = i_hit_dir;
    end else begin
      w_dir_next = r_dir;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_pos <= RST_POS;
      r_dir <= RST_DIR;
    end else if (i_load) begin
      r_acc <= '0;
      r_pos <= i_load_pos;
      r_dir <= i_load_dir;
    end else if (i_en) begin
      r_dir <= w_dir_next;
      if (w_step) begin
        r_acc <= w_sum - AW'(UNIT);
        r_pos <= (w_dir_next == DIR_INC) ? r_pos + 10'd1 : r_pos - 10'd1;
      end else begin
        r_acc <= w_sum;
      end
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_pos = r_pos;
  assign o_dir = r_dir;

endmodule

// File: rtl/ball_engine.sv
// Breakout ball engine: game FSM, lives, multiball and per-ball axis steppers.
module ball_engine
  import ark_pkg::*;
#(
  parameter int BALL_NUM = 4,
  parameter int LIVES    = 3,
  parameter int UNIT     = 2000000,
  parameter int B_RADIUS = 8,
  parameter int PD_H     = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    split,
  input  logic [9:0]              p_x,
  input  logic [9:0]              p_y,
  input  logic [BALL_NUM-1:0]     hit_valid,
  input  logic [2*BALL_NUM-1:0]   hit_dir,
  input  logic [9:0]              blocks_left,
  input  logic [3*BALL_NUM-1:0]   speed,
  output logic [10*BALL_NUM-1:0]  o_bx,
  output logic [10*BALL_NUM-1:0]  o_by,
  output logic [BALL_NUM-1:0]     b_active,
  output logic [2:0]              state,
  output logic [2:0]              lives
);

  localparam logic [9:0] X_LO      = LEFT + 10'(B_RADIUS);
  localparam logic [9:0] X_HI      = LEFT + MAXX - 10'(B_RADIUS);
  localparam logic [9:0] Y_LO      = TOP + 10'(B_RADIUS);
  localparam logic [9:0] Y_HI      = MAXY - 10'(B_RADIUS);
  localparam logic [9:0] TRACK_OFS = 10'(B_RADIUS + PD_H);

  logic [2:0]          r_state;
  logic [2:0]          r_lives;
  logic [BALL_NUM-1:0] r_active;
  logic [2:0]          w_state_next;
  logic [2:0]          w_lives_next;
  logic [BALL_NUM-1:0] w_active_next;
  logic [BALL_NUM-1:0] w_drop;
  logic                w_play;
  logic                w_split_ok;
  logic [9:0]          w_x [BALL_NUM];
  logic [9:0]          w_y [BALL_NUM];
  logic                w_xdir [BALL_NUM];
  logic                w_ydir_unused [BALL_NUM];

  assign w_play     = (r_state == ST_PLAY);
  assign w_split_ok = w_play & split & r_active[0];

  genvar g;
  generate
    for (g = 0; g < BALL_NUM; g++) begin : g_ball
      localparam logic ODD = ((g % 2) == 1);
      logic       w_en;
      logic       w_hit;
      hit_side_t  w_side;
      logic       w_xhit;
      logic       w_yhit;
      logic       w_load;
      logic [9:0] w_lx;
      logic [9:0] w_ly;
      logic       w_ldx;

      assign w_en      = w_play & r_active[g];
      assign w_hit     = w_en & hit_valid[g];
      assign w_side    = hit_side_t'(hit_dir[2*g +: 2]);
      assign w_xhit    = w_hit & ((w_side == HIT_RIGHT) | (w_side == HIT_LEFT));
      assign w_yhit    = w_hit & ((w_side == HIT_UP) | (w_side == HIT_DOWN));
      assign w_drop[g] = w_en & (w_y[g] >= Y_HI);

      // Ball 0 rides the paddle while waiting; the others spawn from ball 0 on split.
      if (g == 0) begin : g_lead
        assign w_load = (r_state == ST_WAIT);
        assign w_lx   = p_x;
        assign w_ly   = p_y - TRACK_OFS;
        assign w_ldx  = DIR_INC;
      end else begin : g_follow
        assign w_load = w_split_ok & ~r_active[g];
        assign w_lx   = w_x[0];
        assign w_ly   = w_y[0];
        assign w_ldx  = w_xdir[0] ^ ODD;
      end

      axis_stepper #(.UNIT(UNIT), .RST_POS(HOME_X), .RST_DIR(DIR_INC)) u_x (
        .clock(clock), .reset(reset), .i_en(w_en), .i_speed(speed[3*g +: 3]),
        .i_load(w_load), .i_load_pos(w_lx), .i_load_dir(w_ldx),
        .i_force_inc(w_x[g] <= X_LO), .i_force_dec(w_x[g] >= X_HI),
        .i_hit(w_xhit), .i_hit_dir(w_side == HIT_RIGHT),
        .o_pos(w_x[g]), .o_dir(w_xdir[g])
      );

      axis_stepper #(.UNIT(UNIT), .RST_POS(HOME_Y), .RST_DIR(DIR_DEC)) u_y (
        .clock(clock), .reset(reset), .i_en(w_en), .i_speed(speed[3*g +: 3]),
        .i_load(w_load), .i_load_pos(w_ly), .i_load_dir(DIR_DEC),
        .i_force_inc(w_y[g] <= Y_LO), .i_force_dec(1'b0),
        .i_hit(w_yhit), .i_hit_dir(w_side == HIT_DOWN),
        .o_pos(w_y[g]), .o_dir(w_ydir_unused[g])
      );

      assign o_bx[10*g +: 10] = w_x[g];
      assign o_by[10*g +: 10] = w_y[g];
    end
  endgenerate

  // Ball activity: launch, bottom drop-out and multiball spawn.
  always_comb begin
    w_active_next = r_active;
    case (r_state)
      ST_WAIT: begin
        w_active_next    = '0;
        w_active_next[0] = start;
      end
      ST_PLAY: begin
        for (int i = 0; i < BALL_NUM; i++) begin
          if (w_drop[i]) begin
            w_active_next[i] = 1'b0;
          end else if (w_split_ok & ~r_active[i]) begin
            w_active_next[i] = 1'b1;
          end else begin
            w_active_next[i] = r_active[i];
          end
        end
      end
      ST_CLEAR: begin
        if (start) begin
          w_active_next = '0;
        end else begin
          w_active_next = r_active;
        end
      end
      default: w_active_next = r_active;
    endcase
  end

  // Game state and lives; a cleared board outranks losing the last ball.
  always_comb begin
    w_state_next = r_state;
    w_lives_next = r_lives;
    case (r_state)
      ST_INIT:  w_state_next = start ? ST_WAIT : ST_INIT;
      ST_WAIT:  w_state_next = start ? ST_PLAY : ST_WAIT;
      ST_PLAY: begin
        if (blocks_left == 10'd0) begin
          w_state_next = ST_CLEAR;
        end else if (w_active_next == '0) begin
          w_state_next = ST_LOST;
        end else if (pause) begin
          w_state_next = ST_PAUSE;
        end else begin
          w_state_next = ST_PLAY;
        end
      end
      ST_PAUSE: w_state_next = pause ? ST_PLAY : ST_PAUSE;
      ST_LOST: begin
        w_lives_next = r_lives - 3'd1;
        w_state_next = (w_lives_next == 3'd0) ? ST_OVER : ST_WAIT;
      end
      ST_OVER: begin
        if (start) begin
          w_state_next = ST_INIT;
          w_lives_next = 3'(LIVES);
        end else begin
          w_state_next = ST_OVER;
        end
      end
      ST_CLEAR: w_state_next = start ? ST_WAIT : ST_CLEAR;
      default:  w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_lives  <= 3'(LIVES);
      r_active <= '0;
    end else begin
      r_state  <= w_state_next;
      r_lives  <= w_lives_next;
      r_active <= w_active_next;
    end
  end

  assign state    = r_state;
  assign lives    = r_lives;
  assign b_active = r_active;

endmodule

// File: tb/tb_ball_engine.sv
// Directed and randomized checks of ball_engine against a behavioural game model.
module tb_ball_engine;

  localparam int NB = 4;
  localparam int LV = 3;
  localparam int UN = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            pause = 1'b0;
  logic            split = 1'b0;
  logic [9:0]      p_x = 10'd300;
  logic [9:0]      p_y = 10'd460;
  logic [NB-1:0]   hit_valid = '0;
  logic [2*NB-1:0] hit_dir = '0;
  logic [9:0]      blocks_left = 10'd100;
  logic [3*NB-1:0] speed = {NB{3'd4}};
  logic [10*NB-1:0] o_bx;
  logic [10*NB-1:0] o_by;
  logic [NB-1:0]   b_active;
  logic [2:0]      state;
  logic [2:0]      lives;

  int vectors = 0;
  int miscompares = 0;

  // Game model: positions as integers, directions as +1/-1.
  int            m_state;
  int            m_lives;
  logic [NB-1:0] m_act;
  int            m_x [NB];
  int            m_y [NB];
  int            m_ax [NB];
  int            m_ay [NB];
  int            m_dx [NB];
  int            m_dy [NB];

  ball_engine #(.BALL_NUM(NB), .LIVES(LV), .UNIT(UN), .B_RADIUS(8), .PD_H(8)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .split(split),
    .p_x(p_x), .p_y(p_y), .hit_valid(hit_valid), .hit_dir(hit_dir),
    .blocks_left(blocks_left), .speed(speed), .o_bx(o_bx), .o_by(o_by),
    .b_active(b_active), .state(state), .lives(lives)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_state = 0;
    m_lives = LV;
    m_act   = '0;
    for (int i = 0; i < NB; i++) begin
      m_x[i] = 320; m_y[i] = 240; m_ax[i] = 0; m_ay[i] = 0; m_dx[i] = 1; m_dy[i] = -1;
    end
  endfunction

  function automatic void m_step();
    logic [NB-1:0] pa;
    int cx0, cy0, cdx0;
    pa = m_act; cx0 = m_x[0]; cy0 = m_y[0]; cdx0 = m_dx[0];
    case (m_state)
      0: if (start) m_state = 1;
      1: begin
        m_x[0] = int'(p_x); m_y[0] = (int'(p_y) - 16) & 1023;
        m_ax[0] = 0; m_ay[0] = 0; m_dx[0] = 1; m_dy[0] = -1;
        m_act = '0;
        if (start) begin m_act[0] = 1'b1; m_state = 2; end
      end
      2: begin
        for (int i = 0; i < NB; i++) begin
          if (pa[i]) begin
            int nx, ny, side, spd;
            nx = m_dx[i]; ny = m_dy[i];
            side = int'(hit_dir[2*i +: 2]);
            spd = int'(speed[3*i +: 3]);
            if (hit_valid[i]) begin
              if (side == 0) ny = -1;
              if (side == 1) nx = 1;
              if (side == 2) ny = 1;
              if (side == 3) nx = -1;
            end
            if (m_x[i] - 8 <= 160) nx = 1;
            else if (m_x[i] + 8 >= 480) nx = -1;
            if (m_y[i] - 8 <= 0) ny = 1;
            if (m_y[i] + 8 >= 480) m_act[i] = 1'b0;
            m_ax[i] += spd;
            if (m_ax[i] >= UN) begin m_ax[i] -= UN; m_x[i] += nx; end
            m_ay[i] += spd;
            if (m_ay[i] >= UN) begin m_ay[i] -= UN; m_y[i] += ny; end
            m_dx[i] = nx; m_dy[i] = ny;
          end
        end
        if (split && pa[0]) begin
          for (int j = 1; j < NB; j++) begin
            if (!pa[j]) begin
              m_x[j] = cx0; m_y[j] = cy0; m_ax[j] = 0; m_ay[j] = 0;
              m_dx[j] = (j % 2 == 1) ? -cdx0 : cdx0; m_dy[j] = -1; m_act[j] = 1'b1;
            end
          end
        end
        if (blocks_left == 10'd0) m_state = 6;
        else if (m_act == '0) m_state = 4;
        else if (pause) m_state = 3;
      end
      3: if (pause) m_state = 2;
      4: begin m_lives--; m_state = (m_lives == 0) ? 5 : 1; end
      5: if (start) begin m_state = 0; m_lives = LV; end
      6: if (start) begin m_state = 1; m_act = '0; end
      default: m_state = 0;
    endcase
  endfunction

  task automatic compare_all();
    logic [10*NB-1:0] ebx, eby;
    for (int i = 0; i < NB; i++) begin
      ebx[10*i +: 10] = 10'(m_x[i]);
      eby[10*i +: 10] = 10'(m_y[i]);
    end
    check("state", 64'(state), 64'(m_state));
    check("lives", 64'(lives), 64'(m_lives));
    check("b_active", 64'(b_active), 64'(m_act));
    check("o_bx", 64'(o_bx), 64'(ebx));
    check("o_by", 64'(o_by), 64'(eby));
  endtask

  task automatic step();
    m_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 m_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int maxx, y_e;
    #1 reset = 1'b1;
    #1 m_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b0;

    // Launch from the paddle and watch the fractional stepping.
    pulse_start();
    step();
    check("wait_x", 64'(o_bx[9:0]), 64'd300);
    check("wait_y", 64'(o_by[9:0]), 64'd444);
    pulse_start();
    check("launch_state", 64'(state), 64'd2);
    check("launch_active", 64'(b_active), 64'b0001);
    repeat (3) step();
    check("x_before_step", 64'(o_bx[9:0]), 64'd300);
    step();
    check("x_first_step", 64'(o_bx[9:0]), 64'd301);
    check("y_first_step", 64'(o_by[9:0]), 64'd443);

    // Right wall reversal.
    maxx = 0;
    for (int k = 0; k < 2000 && o_bx[9:0] != 10'd472; k++) begin
      step();
      if (int'(o_bx[9:0]) > maxx) maxx = int'(o_bx[9:0]);
    end
    check("reach_472", 64'(o_bx[9:0]), 64'd472);
    repeat (4) begin
      step();
      if (int'(o_bx[9:0]) > maxx) maxx = int'(o_bx[9:0]);
    end
    check("reverse_471", 64'(o_bx[9:0]), 64'd471);
    check("x_max_le_472", 64'(maxx <= 472), 64'd1);

    // Up-hit while touching the left wall with y moving down the screen.
    for (int k = 0; k < 3000 && o_bx[9:0] != 10'd168; k++) step();
    check("reach_168", 64'(o_bx[9:0]), 64'd168);
    y_e = int'(o_by[9:0]);
    hit_valid = 4'b0001; hit_dir = 8'b00;
    step();
    hit_valid = '0;
    repeat (3) step();
    check("wall_x_inc", 64'(o_bx[9:0]), 64'd169);
    check("hit_up_y_dec", 64'(o_by[9:0]), 64'(10'(y_e - 1)));

    // Asynchronous reset in the middle of play, then multiball.
    async_reset();
    check("rst_state", 64'(state), 64'd0);
    check("rst_active", 64'(b_active), 64'd0);
    pulse_start();
    p_x = 10'd320; p_y = 10'd216;
    step();
    check("split_home_y", 64'(o_by[9:0]), 64'd200);
    pulse_start();
    split = 1'b1; step(); split = 1'b0;
    check("split_active", 64'(b_active), 64'b1111);
    repeat (16) step();
    check("split_b1_opp", 64'(o_bx[19:10] < o_bx[9:0]), 64'd1);
    check("split_b3_opp", 64'(o_bx[39:30] < o_bx[9:0]), 64'd1);
    check("split_b2_same", 64'(o_bx[29:20] > 10'd320), 64'd1);

    // Randomized play against the model.
    for (int k = 0; k < 2500; k++) begin
      for (int i = 0; i < NB; i++) speed[3*i +: 3] = 3'($urandom_range(1, 7));
      hit_valid   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      hit_dir     = 8'($urandom);
      start       = ($urandom_range(0, 15) == 0);
      pause       = ($urandom_range(0, 63) == 0);
      split       = ($urandom_range(0, 31) == 0);
      blocks_left = ($urandom_range(0, 299) == 0) ? 10'd0 : 10'($urandom_range(1, 900));
      p_x         = 10'($urandom_range(200, 440));
      p_y         = 10'($urandom_range(300, 470));
      step();
    end
    start = 1'b0; pause = 1'b0; split = 1'b0; hit_valid = '0; blocks_left = 10'd100;

    // Lose all lives, one cycle in LOST each time.
    async_reset();
    speed = {NB{3'd7}};
    p_x = 10'd300; p_y = 10'd470;
    pulse_start();
    for (int life = 0; life < 3; life++) begin
      step();
      pulse_start();
      hit_valid = 4'b0001; hit_dir = 8'b10;
      step();
      hit_valid = '0;
      for (int k = 0; k < 500 && state == 3'd2; k++) step();
      check("lost_state", 64'(state), 64'd4);
      check("lost_lives", 64'(lives), 64'(3 - life));
      step();
      check("after_lost_state", 64'(state), (life == 2) ? 64'd5 : 64'd1);
      check("after_lost_lives", 64'(lives), 64'(2 - life));
    end
    pulse_start();
    check("over_init_state", 64'(state), 64'd0);
    check("over_init_lives", 64'(lives), 64'd3);

    // Board cleared on the same cycle the last ball drops.
    pulse_start();
    step();
    pulse_start();
    hit_valid = 4'b0001; hit_dir = 8'b10;
    step();
    hit_valid = '0;
    for (int k = 0; k < 500 && o_by[9:0] < 10'd472; k++) step();
    check("drop_ready", 64'(o_by[9:0] >= 10'd472), 64'd1);
    blocks_left = 10'd0;
    step();
    check("clear_state", 64'(state), 64'd6);
    check("clear_lives", 64'(lives), 64'd3);
    blocks_left = 10'd100;
    pulse_start();
    check("clear_to_wait", 64'(state), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
